puf_req_arbiter: RTL and testbench

PUF_REQ_ARBITER -- requirements
Module: puf_req_arbiter

---
 rtl/puf_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/puf_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_puf_req_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_arb_pkg.sv
// Shared types and constants for the PUF request arbiter.
package puf_arb_pkg;

  localparam int unsigned PUF_CHAL_W  = 16;
  localparam int unsigned PUF_RESP_W  = 128;
  localparam int unsigned LOAD_CYCLES = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StResp
  } puf_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first requester at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Requester i sits at distance k from ptr when ptr == (i - k) mod NUM_REQ;
  // scan distances in increasing order so the nearest active requester wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (ptr == PTR_W'((i + NUM_REQ - k) % NUM_REQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/puf_req_arbiter.sv
// Shares one PUF engine among NUM_REQ requesters with round-robin arbitration.
// Optional RUN-state watchdog enabled by defining PUF_ARB_TIMEOUT_EN.
module puf_req_arbiter
  import puf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*PUF_CHAL_W-1:0] req_chal,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [PUF_RESP_W-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          eng_rst,
  output logic [PUF_CHAL_W-1:0]         eng_chal,
  input  logic                          eng_done,
  input  logic [PUF_RESP_W-1:0]         eng_resp,
  output logic                          busy
);

  puf_arb_state_e          state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [1:0]              load_cnt_q, load_cnt_d;
  logic [PUF_CHAL_W-1:0]   eng_chal_q, eng_chal_d;
  logic [ID_W-1:0]         resp_id_q, resp_id_d;
  logic [PUF_RESP_W-1:0]   resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         win_id;
  logic [PUF_CHAL_W-1:0]   win_chal;

`ifdef PUF_ARB_TIMEOUT_EN
  localparam int unsigned TO_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] run_cnt_q, run_cnt_d;
  logic            resp_err_q, resp_err_d;
  logic            timeout;
  assign timeout  = (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign resp_err = resp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign resp_err       = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // One-hot grant to index and selected challenge.
  always_comb begin
    win_id   = '0;
    win_chal = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id   = ID_W'(i);
        win_chal = req_chal[i*PUF_CHAL_W +: PUF_CHAL_W];
      end
    end
  end

  // Next-state and datapath updates for the request/engine/response sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_cnt_d  = load_cnt_q;
    eng_chal_d  = eng_chal_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
`ifdef PUF_ARB_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
    resp_err_d  = resp_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (|(req_valid & grant)) begin
          eng_chal_d = win_chal;
          resp_id_d  = win_id;
          load_cnt_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (load_cnt_q == 2'(LOAD_CYCLES - 1)) begin
          state_d = StRun;
`ifdef PUF_ARB_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // A done arriving in the watchdog's final cycle still delivers data.
        if (eng_done) begin
          resp_data_d = eng_resp;
          state_d     = StResp;
`ifdef PUF_ARB_TIMEOUT_EN
          resp_err_d  = 1'b0;
        end else if (timeout) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = StResp;
        end else begin
          run_cnt_d   = run_cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          ptr_d   = (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      load_cnt_q  <= '0;
      eng_chal_q  <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
`ifdef PUF_ARB_TIMEOUT_EN
      run_cnt_q   <= '0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_cnt_q  <= load_cnt_d;
      eng_chal_q  <= eng_chal_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
`ifdef PUF_ARB_TIMEOUT_EN
      run_cnt_q   <= run_cnt_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle) ? grant : '0;
  assign resp_valid = (state_q == StResp);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign eng_chal   = eng_chal_q;
  assign eng_rst    = (state_q != StRun);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_puf_req_arbiter.sv
// Directed self-checking bench for puf_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=100).
module tb_puf_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [63:0]  req_chal;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         eng_rst;
  logic [15:0]  eng_chal;
  logic         eng_done;
  logic [127:0] eng_resp;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  puf_req_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_chal   (req_chal),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .eng_rst    (eng_rst),
    .eng_chal   (eng_chal),
    .eng_done   (eng_done),
    .eng_resp   (eng_resp),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: grant, 2 LOAD cycles, done in RUN cycle n_run, optional RESP stall.
  task automatic run_txn(input int id, input logic [15:0] chal, input int n_run,
                         input logic [127:0] data, input int stall);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    check("grant", 128'(req_ready), 128'(onehot));
    tick();
    check("load1_eng_rst", 128'(eng_rst), 128'(1'b1));
    check("load1_busy", 128'(busy), 128'(1'b1));
    check("load1_ready", 128'(req_ready), 128'(4'b0000));
    tick();
    check("load2_eng_rst", 128'(eng_rst), 128'(1'b1));
    tick();
    check("run_eng_rst", 128'(eng_rst), 128'(1'b0));
    check("run_chal", 128'(eng_chal), 128'(chal));
    repeat (n_run - 1) tick();
    check("run_still", 128'(resp_valid), 128'(1'b0));
    eng_done = 1'b1;
    eng_resp = data;
    tick();
    eng_done = 1'b0;
    eng_resp = '0;
    check("resp_valid", 128'(resp_valid), 128'(1'b1));
    check("resp_id", 128'(resp_id), 128'(id));
    check("resp_data", resp_data, data);
    check("resp_err", 128'(resp_err), 128'(1'b0));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 128'(resp_valid), 128'(1'b1));
      check("stall_data", resp_data, data);
      check("stall_ready", 128'(req_ready), 128'(4'b0000));
      check("stall_busy", 128'(busy), 128'(1'b1));
      check("stall_eng_rst", 128'(eng_rst), 128'(1'b1));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("idle_valid", 128'(resp_valid), 128'(1'b0));
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_chal   = {16'h3333, 16'h2222, 16'hACE1, 16'h1000};
    resp_ready = 1'b0;
    eng_done   = 1'b0;
    eng_resp   = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_eng_rst", 128'(eng_rst), 128'(1'b1));
    check("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
    check("rst_resp_id", 128'(resp_id), 128'(2'd0));
    check("rst_resp_data", resp_data, 128'd0);
    check("rst_resp_err", 128'(resp_err), 128'(1'b0));
    check("rst_eng_chal", 128'(eng_chal), 128'(16'h0));
    check("rst_ready", 128'(req_ready), 128'(4'b0000));

    // All requesters held: grant order 0,1,2,3,0
    req_valid = 4'b1111;
    #1;
    run_txn(0, 16'h1000, 1, 128'hA0, 0);
    run_txn(1, 16'hACE1, 1, 128'hA1, 0);
    run_txn(2, 16'h2222, 1, 128'hA2, 0);
    run_txn(3, 16'h3333, 1, 128'hA3, 0);
    run_txn(0, 16'h1000, 1, 128'hA4, 0);

    // Requester 1 alone, done after 40 RUN cycles, 10-cycle response stall
    req_valid = 4'b0010;
    #1;
    run_txn(1, 16'hACE1, 40, 128'h00112233445566778899AABBCCDDEEFF, 10);
    req_valid = 4'b0000;

    // Request withdrawn before handshake is never granted
    req_valid = 4'b0100;
    #1;
    check("drop_ready", 128'(req_ready), 128'(4'b0100));
    req_valid = 4'b0000;
    tick();
    check("drop_busy", 128'(busy), 128'(1'b0));

    // Engine never finishes
    req_chal[47:32] = 16'hBEEF;
    req_valid = 4'b0100;
    #1;
    check("to_grant", 128'(req_ready), 128'(4'b0100));
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("to_run_eng_rst", 128'(eng_rst), 128'(1'b0));
    check("to_run_chal", 128'(eng_chal), 128'(16'hBEEF));
`ifdef PUF_ARB_TIMEOUT_EN
    repeat (99) tick();
    check("to_before", 128'(resp_valid), 128'(1'b0));
    tick();
    check("to_valid", 128'(resp_valid), 128'(1'b1));
    check("to_err", 128'(resp_err), 128'(1'b1));
    check("to_data", resp_data, 128'd0);
    check("to_id", 128'(resp_id), 128'(2'd2));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Done coincident with the watchdog expiry wins
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    repeat (99) tick();
    eng_done = 1'b1;
    eng_resp = 128'hCAFE_F00D;
    tick();
    eng_done = 1'b0;
    eng_resp = '0;
    check("co_valid", 128'(resp_valid), 128'(1'b1));
    check("co_err", 128'(resp_err), 128'(1'b0));
    check("co_data", resp_data, 128'hCAFE_F00D);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
`else
    repeat (150) tick();
    check("nto_valid", 128'(resp_valid), 128'(1'b0));
    check("nto_busy", 128'(busy), 128'(1'b1));
    check("nto_eng_rst", 128'(eng_rst), 128'(1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("nto_rst_busy", 128'(busy), 128'(1'b0));
`endif

    // Reset mid-RUN discards the request and restarts arbitration at 0
    req_valid = 4'b0100;
    #1;
    run_txn(2, 16'hBEEF, 3, 128'h55, 0);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("mid_run", 128'(eng_rst), 128'(1'b0));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 128'(busy), 128'(1'b0));
    check("mid_rst_eng_rst", 128'(eng_rst), 128'(1'b1));
    check("mid_rst_valid", 128'(resp_valid), 128'(1'b0));
    check("mid_rst_chal", 128'(eng_chal), 128'(16'h0));
    check("mid_rst_data", resp_data, 128'd0);
    req_valid = 4'b1111;
    #1;
    check("mid_rst_grant", 128'(req_ready), 128'(4'b0001));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
